// File: rtl/pattern_tx.sv
// Serial pattern transmitter: emits a captured bit pattern MSB-first, repeated
// reps+1 times with a one-cycle gap between copies, then pulses done.
module pattern_tx (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] pattern,
    input  logic [2:0] len,
    input  logic [1:0] reps,
    output logic       w,
    output logic       w_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] CurState
);

    localparam int unsigned PAT_W = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned REP_W = 2;
    localparam int unsigned ST_W  = 4;

    typedef enum logic [ST_W-1:0] {
        IDLE = 4'd0,
        SEND = 4'd1,
        GAP  = 4'd2,
        DONE = 4'd3
    } state_t;

    state_t             state, state_next;
    logic [PAT_W-1:0]   pat_q, pat_n;
    logic [IDX_W-1:0]   len_q, len_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [REP_W-1:0]   rep_q, rep_n;
    logic               w_n, w_valid_n, busy_n, done_n;

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        pat_n      = pat_q;
        len_n      = len_q;
        idx_n      = idx_q;
        rep_n      = rep_q;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    pat_n      = pattern;
                    len_n      = len;
                    idx_n      = len;
                    rep_n      = reps;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    idx_n      = IDX_W'(0);
                    rep_n      = REP_W'(0);
                    state_next = IDLE;
                end else if (idx_q == IDX_W'(0)) begin
                    state_next = (rep_q != REP_W'(0)) ? GAP : DONE;
                end else begin
                    idx_n = idx_q - IDX_W'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    idx_n      = IDX_W'(0);
                    rep_n      = REP_W'(0);
                    state_next = IDLE;
                end else begin
                    rep_n      = rep_q - REP_W'(1);
                    idx_n      = len_q;
                    state_next = SEND;
                end
            end
            DONE: begin
                idx_n      = IDX_W'(0);
                rep_n      = REP_W'(0);
                state_next = IDLE;
            end
            default: begin
                idx_n      = IDX_W'(0);
                rep_n      = REP_W'(0);
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are the Moore decode of the upcoming state, registered alongside it
    always_comb begin
        w_n       = 1'b0;
        w_valid_n = 1'b0;
        busy_n    = (state_next != IDLE);
        done_n    = (state_next == DONE);
        if (state_next == SEND) begin
            w_n       = pat_n[idx_n];
            w_valid_n = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state   <= IDLE;
            pat_q   <= PAT_W'(0);
            len_q   <= IDX_W'(0);
            idx_q   <= IDX_W'(0);
            rep_q   <= REP_W'(0);
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            pat_q   <= pat_n;
            len_q   <= len_n;
            idx_q   <= idx_n;
            rep_q   <= rep_n;
            w       <= w_n;
            w_valid <= w_valid_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    assign CurState = state;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: checks bit streams, gaps, done pulse, abort and reset.
module tb_pattern_tx;

    logic       Clock;
    logic       Resetn;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [2:0] len;
    logic [1:0] reps;
    logic       w;
    logic       w_valid;
    logic       busy;
    logic       done;
    logic [3:0] CurState;

    int         n_vec = 0;
    int         n_err = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    int         b0;
    int         d0;
    logic [3:0] sr = 4'h0;

    pattern_tx dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .start    (start),
        .abort    (abort),
        .pattern  (pattern),
        .len      (len),
        .reps     (reps),
        .w        (w),
        .w_valid  (w_valid),
        .busy     (busy),
        .done     (done),
        .CurState (CurState)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Mid-cycle monitor: valid-bit shift register (detector view), busy and done counts
    always @(negedge Clock) begin
        if (w_valid) sr <= {sr[2:0], w};
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Expected {CurState, busy, done, w_valid, w} for a given state
    function automatic logic [7:0] exp_of(input logic [3:0] st, input logic wb);
        case (st)
            4'd1:    return {4'd1, 1'b1, 1'b0, 1'b1, wb};
            4'd2:    return {4'd2, 4'b1000};
            4'd3:    return {4'd3, 4'b1100};
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk_st(input string tag, input logic [3:0] st, input logic wb);
        chk(tag, {CurState, busy, done, w_valid, w}, exp_of(st, wb));
    endtask

    task automatic send_bits(input string tag, input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            chk_st($sformatf("%s_bit%0d", tag, n - 1 - i), 4'd1, bits[i]);
            tick();
        end
    endtask

    task automatic go(input logic [7:0] p, input logic [2:0] l, input logic [1:0] r);
        pattern = p;
        len     = l;
        reps    = r;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        Resetn  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = 8'h00;
        len     = 3'd0;
        reps    = 2'd0;
        tick();
        tick();
        chk_st("reset_state", 4'd0, 1'b0);
        Resetn = 1'b1;

        // 0x0D, 4 bits, single copy
        d0 = done_cnt;
        go(8'h0D, 3'd3, 2'd0);
        send_bits("p0d", 8'h0D, 4);
        chk("det_1101", {4'h0, sr}, 8'h0D);
        chk_st("p0d_done", 4'd3, 1'b0);
        tick();
        chk_st("p0d_idle", 4'd0, 1'b0);
        chk("p0d_done_pulses", 8'(done_cnt - d0), 8'd1);

        // 0x0F, 4 bits, three copies with gaps
        b0 = busy_cnt;
        go(8'h0F, 3'd3, 2'd2);
        send_bits("p0f_a", 8'h0F, 4);
        chk("det_1111", {4'h0, sr}, 8'h0F);
        chk_st("p0f_gap1", 4'd2, 1'b0);
        tick();
        send_bits("p0f_b", 8'h0F, 4);
        chk_st("p0f_gap2", 4'd2, 1'b0);
        tick();
        send_bits("p0f_c", 8'h0F, 4);
        chk_st("p0f_done", 4'd3, 1'b0);
        tick();
        chk_st("p0f_idle", 4'd0, 1'b0);
        chk("p0f_busy_cycles", 8'(busy_cnt - b0), 8'd15);

        // Single-bit pattern, then full 8-bit 0xA5
        go(8'h01, 3'd0, 2'd0);
        send_bits("len0", 8'h01, 1);
        chk_st("len0_done", 4'd3, 1'b0);
        tick();
        chk_st("len0_idle", 4'd0, 1'b0);
        go(8'hA5, 3'd7, 2'd0);
        send_bits("pa5", 8'hA5, 8);
        chk_st("pa5_done", 4'd3, 1'b0);
        tick();
        chk_st("pa5_idle", 4'd0, 1'b0);

        // Abort during the second SEND bit
        d0 = done_cnt;
        go(8'h0D, 3'd3, 2'd1);
        chk_st("ab_bit0", 4'd1, 1'b1);
        tick();
        chk_st("ab_bit1", 4'd1, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_st("ab_idle", 4'd0, 1'b0);
        go(8'h01, 3'd0, 2'd0);
        chk_st("ab_restart", 4'd1, 1'b1);
        tick();
        chk_st("ab_restart_done", 4'd3, 1'b0);
        tick();

        // Abort in GAP
        go(8'h01, 3'd0, 2'd1);
        chk_st("abgap_bit", 4'd1, 1'b1);
        tick();
        chk_st("abgap_gap", 4'd2, 1'b0);
        abort = 1'b1;
        tick();
        chk_st("abgap_idle", 4'd0, 1'b0);
        chk("abort_no_done", 8'(done_cnt - d0), 8'd1);

        // Abort in IDLE, abort beats start, then start held high
        tick();
        chk_st("abidle", 4'd0, 1'b0);
        pattern = 8'h01;
        len     = 3'd0;
        reps    = 2'd0;
        start   = 1'b1;
        tick();
        chk_st("abort_wins", 4'd0, 1'b0);
        abort = 1'b0;
        tick();
        chk_st("held_send1", 4'd1, 1'b1);
        tick();
        chk_st("held_done1", 4'd3, 1'b0);
        tick();
        chk_st("held_idle", 4'd0, 1'b0);
        tick();
        chk_st("held_send2", 4'd1, 1'b1);
        start = 1'b0;
        tick();
        chk_st("held_done2", 4'd3, 1'b0);
        tick();
        chk_st("held_idle2", 4'd0, 1'b0);

        // Input changes and start while busy do not disturb the stream
        go(8'h0D, 3'd3, 2'd0);
        chk_st("busy_chg_bit0", 4'd1, 1'b1);
        start   = 1'b1;
        pattern = 8'h00;
        len     = 3'd0;
        reps    = 2'd3;
        tick();
        start = 1'b0;
        send_bits("busy_chg_rest", 8'h05, 3);
        chk_st("busy_chg_done", 4'd3, 1'b0);
        tick();
        chk_st("busy_chg_idle", 4'd0, 1'b0);

        // Reset mid-SEND beats abort and start; first start after release
        d0 = done_cnt;
        go(8'h0D, 3'd3, 2'd0);
        chk_st("rst_bit0", 4'd1, 1'b1);
        tick();
        Resetn = 1'b0;
        abort  = 1'b1;
        start  = 1'b1;
        tick();
        chk_st("rst_cyc1", 4'd0, 1'b0);
        tick();
        chk_st("rst_cyc2", 4'd0, 1'b0);
        Resetn  = 1'b1;
        abort   = 1'b0;
        pattern = 8'h0D;
        len     = 3'd3;
        reps    = 2'd0;
        tick();
        start = 1'b0;
        send_bits("post_rst", 8'h0D, 4);
        chk_st("post_rst_done", 4'd3, 1'b0);
        tick();
        chk_st("post_rst_idle", 4'd0, 1'b0);
        chk("rst_done_pulses", 8'(done_cnt - d0), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
